udp_tx_arbiter: RTL and testbench

UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

---
 rtl/udp_stream_pkg.sv | 20 ++
 rtl/rr_pick.sv | 33 +++
 rtl/udp_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_udp_tx_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_stream_pkg.sv
// Shared definitions for the UDP transmit stream path.
//   arb_state_e : arbiter FSM state (IDLE waits for a requester, PASS forwards one frame)
//   BEAT_W      : default AXI-Stream beat width in bits
//   KEEP_W      : default byte-enable width (BEAT_W/8)
//   rr_idx_w()  : width of a source index for a given source count (minimum 1 bit)
package udp_stream_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } arb_state_e;

  localparam int BEAT_W = 64;
  localparam int KEEP_W = BEAT_W / 8;

  function automatic int rr_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority search.
//   req_i   : request vector, one bit per source
//   last_i  : index of the previously granted source
//   idx_o   : first requesting index searching from last_i+1 upward, wrapping at N
//   valid_o : high when any request bit is set (idx_o is 0 otherwise)
// Purely combinational; the caller registers the result.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] cand;

  // Offsets 1..N visit every source exactly once, last_i itself being checked last.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int off = 1; off <= N; off++) begin
      cand = IW'((int'(last_i) + off) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Frame-atomic round-robin merge of NUM_SRC AXI-Stream sources onto one MAC TX stream.
//   axis_aclk / axis_areset       : clock, synchronous active-high reset
//   s_axis_t{data,keep,valid,last,user} : packed source streams, source k in slice k
//   s_axis_tready                 : per-source ready
//   m00_axis_t{data,keep,valid,last,user}, m00_axis_tready : merged stream to the MAC
//   src_enable                    : per-source arbitration mask
//   grant_idx                     : current or most recently granted source
//   busy                          : FSM state exposure, high in PASS (frame in flight)
//   frame_count                   : packed 32-bit per-source completed-frame counters
//
// Handshake: a beat transfers on a rising edge where valid and ready are both high.
// Ready is a pure combinational pass-through of m00_axis_tready to the granted source
// only; valid may be dropped by the source between beats without releasing the grant.
// The grant is released solely by the tlast handshake (or reset).
module udp_tx_arbiter
  import udp_stream_pkg::*;
#(
  parameter int NUM_SRC            = 4,
  parameter int C_AXIS_TDATA_WIDTH = BEAT_W,
  parameter int C_AXIS_TKEEP_WIDTH = KEEP_W,
  localparam int IW                = rr_idx_w(NUM_SRC)
) (
  input  logic                                  axis_aclk,
  input  logic                                  axis_areset,
  input  logic [NUM_SRC*C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC*C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [NUM_SRC-1:0]                    s_axis_tvalid,
  input  logic [NUM_SRC-1:0]                    s_axis_tlast,
  input  logic [NUM_SRC-1:0]                    s_axis_tuser,
  output logic [NUM_SRC-1:0]                    s_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]         m00_axis_tdata,
  output logic [C_AXIS_TKEEP_WIDTH-1:0]         m00_axis_tkeep,
  output logic                                  m00_axis_tvalid,
  output logic                                  m00_axis_tlast,
  output logic                                  m00_axis_tuser,
  input  logic                                  m00_axis_tready,
  input  logic [NUM_SRC-1:0]                    src_enable,
  output logic [IW-1:0]                         grant_idx,
  output logic                                  busy,
  output logic [NUM_SRC*32-1:0]                 frame_count
);

  localparam int W  = C_AXIS_TDATA_WIDTH;
  localparam int KW = C_AXIS_TKEEP_WIDTH;

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [31:0]   cnt_q [NUM_SRC];

  logic [NUM_SRC-1:0] req;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic               last_hs;

  assign req = s_axis_tvalid & src_enable;

  rr_pick #(
    .N  (NUM_SRC),
    .IW (IW)
  ) u_pick (
    .req_i   (req),
    .last_i  (grant_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign last_hs = (state_q == ST_PASS) & m00_axis_tvalid & m00_axis_tready & m00_axis_tlast;

  // State register. grant_q resets to the top index so the first search begins at source 0.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state_q <= ST_IDLE;
      grant_q <= IW'(NUM_SRC - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Next-state logic. grant only changes on entry to PASS, so it also holds the last winner.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_PASS;
          grant_d = pick_idx;
        end
      end
      ST_PASS: begin
        if (last_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output mux: everything is zero in IDLE; in PASS the granted slice is forwarded.
  always_comb begin
    m00_axis_tdata  = '0;
    m00_axis_tkeep  = '0;
    m00_axis_tvalid = 1'b0;
    m00_axis_tlast  = 1'b0;
    m00_axis_tuser  = 1'b0;
    s_axis_tready   = '0;
    if (state_q == ST_PASS) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (grant_q == IW'(k)) begin
          m00_axis_tdata   = s_axis_tdata[k*W +: W];
          m00_axis_tkeep   = s_axis_tkeep[k*KW +: KW];
          m00_axis_tvalid  = s_axis_tvalid[k];
          m00_axis_tlast   = s_axis_tlast[k];
          m00_axis_tuser   = s_axis_tuser[k];
          s_axis_tready[k] = m00_axis_tready;
        end
      end
    end
  end

  // Completed-frame counters; reset wins over a same-edge tlast handshake.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      for (int k = 0; k < NUM_SRC; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (last_hs && grant_q == IW'(k)) cnt_q[k] <= cnt_q[k] + 32'd1;
      end
    end
  end

  always_comb begin
    frame_count = '0;
    for (int k = 0; k < NUM_SRC; k++) frame_count[k*32 +: 32] = cnt_q[k];
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q == ST_PASS);

endmodule

// File: tb/tb_udp_tx_arbiter.sv
module tb_udp_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int KW = 8;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
  } beat_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic axis_areset;

  logic [N*W-1:0]  s_axis_tdata;
  logic [N*KW-1:0] s_axis_tkeep;
  logic [N-1:0]    s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_tready;
  logic [W-1:0]    m00_axis_tdata;
  logic [KW-1:0]   m00_axis_tkeep;
  logic            m00_axis_tvalid, m00_axis_tlast, m00_axis_tuser, m00_axis_tready;
  logic [N-1:0]    src_enable;
  logic [1:0]      grant_idx;
  logic            busy;
  logic [N*32-1:0] frame_count;

  udp_tx_arbiter #(.NUM_SRC(N), .C_AXIS_TDATA_WIDTH(W), .C_AXIS_TKEEP_WIDTH(KW)) dut (
    .axis_aclk(clk), .axis_areset(axis_areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
    .m00_axis_tdata(m00_axis_tdata), .m00_axis_tkeep(m00_axis_tkeep),
    .m00_axis_tvalid(m00_axis_tvalid), .m00_axis_tlast(m00_axis_tlast),
    .m00_axis_tuser(m00_axis_tuser), .m00_axis_tready(m00_axis_tready),
    .src_enable(src_enable), .grant_idx(grant_idx), .busy(busy), .frame_count(frame_count)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;

  beat_t src_q [N][$];   // beats each source still has to send
  beat_t cur_beat [N];   // beat currently driven by each source
  logic  [N-1:0] acc;    // source beat accepted on the coming edge
  logic  flush;
  int    p_valid = 100, p_ready = 100, p_drop = 0;

  // reference model: who owns the output, who won last, completed frames
  bit          m_active = 0;
  int          m_grant  = N - 1;
  logic [31:0] m_cnt [N];
  int          hs_cnt [N];
  int          grant_log [$];
  logic [KW-1:0] last_keep_obs;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor + model (negedge) ----------------
  initial begin : monitor
    logic [N*32-1:0] exp_fc;
    logic [N-1:0]    exp_rdy;
    logic [N-1:0]    rq;
    int o, w;
    bit found;
    for (int k = 0; k < N; k++) begin m_cnt[k] = '0; hs_cnt[k] = 0; end
    forever begin
      @(negedge clk);
      o = m_grant;
      chk("busy", busy, m_active);
      chk("grant_idx", grant_idx, m_grant);
      for (int k = 0; k < N; k++) exp_fc[k*32 +: 32] = m_cnt[k];
      chk("frame_count", frame_count, exp_fc);
      if (!m_active) begin
        chk("idle_tvalid", m00_axis_tvalid, 0);
        chk("idle_tlast", m00_axis_tlast, 0);
        chk("idle_tready", s_axis_tready, 0);
      end else begin
        exp_rdy = '0;
        exp_rdy[o] = m00_axis_tready;
        chk("pass_tvalid", m00_axis_tvalid, s_axis_tvalid[o]);
        chk("pass_tready", s_axis_tready, exp_rdy);
        if (s_axis_tvalid[o]) begin
          chk("pass_tdata", m00_axis_tdata, cur_beat[o].data);
          chk("pass_tkeep", m00_axis_tkeep, cur_beat[o].keep);
          chk("pass_tlast", m00_axis_tlast, cur_beat[o].last);
          chk("pass_tuser", m00_axis_tuser, cur_beat[o].user);
        end
      end
      acc = s_axis_tvalid & s_axis_tready;
      // what the coming edge must do
      if (axis_areset) begin
        m_active = 0; m_grant = N - 1; flush = 1;
        for (int k = 0; k < N; k++) m_cnt[k] = '0;
      end else if (!m_active) begin
        rq = s_axis_tvalid & src_enable;
        found = 0; w = 0;
        for (int off = 1; off <= N; off++)
          if (!found && rq[(m_grant + off) % N]) begin found = 1; w = (m_grant + off) % N; end
        if (found) begin m_active = 1; m_grant = w; grant_log.push_back(w); end
      end else if (s_axis_tvalid[o] && m00_axis_tready) begin
        hs_cnt[o]++;
        if (cur_beat[o].last) begin
          m_active = 0;
          m_cnt[o] = m_cnt[o] + 32'd1;
          last_keep_obs = m00_axis_tkeep;
        end
      end
    end
  end

  // ---------------- source / sink driver (posedge + 1) ----------------
  task automatic drive_src(input int k);
    s_axis_tdata[k*W +: W]   = cur_beat[k].data;
    s_axis_tkeep[k*KW +: KW] = cur_beat[k].keep;
    s_axis_tlast[k]          = cur_beat[k].last;
    s_axis_tuser[k]          = cur_beat[k].user;
  endtask

  initial begin : driver
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = '0;
    s_axis_tlast = '0; s_axis_tuser = '0; m00_axis_tready = 1'b0;
    acc = '0; flush = 0;
    for (int k = 0; k < N; k++) cur_beat[k] = '0;
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (flush) begin
          src_q[k].delete();
          s_axis_tvalid[k] = 1'b0;
        end else begin
          if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
          if (src_q[k].size() == 0) s_axis_tvalid[k] = 1'b0;
          else if (s_axis_tvalid[k] && !acc[k])
            s_axis_tvalid[k] = !($urandom_range(99) < p_drop);
          else s_axis_tvalid[k] = ($urandom_range(99) < p_valid);
        end
        cur_beat[k] = (src_q[k].size() > 0) ? src_q[k][0] : '0;
        drive_src(k);
      end
      m00_axis_tready = ($urandom_range(99) < p_ready);
      flush = 0;
    end
  end

  // ---------------- scenario helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic push_frame(input int k, input int len, input logic [KW-1:0] lkeep, input bit same);
    beat_t b;
    logic [W-1:0] d;
    d = {$urandom, $urandom};
    for (int i = 0; i < len; i++) begin
      b.data = same ? d : {$urandom, $urandom};
      b.keep = (i == len - 1) ? lkeep : {KW{1'b1}};
      b.last = (i == len - 1);
      b.user = 1'($urandom_range(1));
      src_q[k].push_back(b);
    end
  endtask

  function automatic bit pending(input logic [N-1:0] mask);
    bit p;
    p = m_active;
    for (int k = 0; k < N; k++) if (mask[k] && src_q[k].size() > 0) p = 1;
    return p;
  endfunction

  task automatic drain(input string tag, input logic [N-1:0] mask, input int budget);
    int n;
    n = 0;
    while (pending(mask) && n < budget) begin cyc(1); n++; end
    if (n >= budget) chk({tag, "_timeout"}, 1, 0);
  endtask

  task automatic wait_hs(input string tag, input int k, input int target, input int budget);
    int n;
    n = 0;
    while (hs_cnt[k] < target && n < budget) begin cyc(1); n++; end
    if (n >= budget) chk({tag, "_timeout"}, 1, 0);
  endtask

  task automatic do_reset(input int n);
    axis_areset = 1'b1;
    cyc(n);
    axis_areset = 1'b0;
    grant_log.delete();
  endtask

  // ---------------- scenarios ----------------
  initial begin : scenario
    int base;
    axis_areset = 1'b1;
    src_enable  = '1;
    cyc(3);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_idx, N - 1);
    chk("rst_fc", frame_count, 0);
    chk("rst_tready", s_axis_tready, 0);
    axis_areset = 1'b0;
    cyc(1);

    // 22-beat frame of identical beats from source 0, last keep 0x03
    base = hs_cnt[0];
    push_frame(0, 22, 8'h03, 1);
    drain("t036", '1, 200);
    chk("t036_beats", hs_cnt[0] - base, 22);
    chk("t036_lastkeep", last_keep_obs, 8'h03);
    chk("t036_fc0", frame_count[31:0], 1);
    chk("t036_grant", grant_idx, 0);

    // all sources ready at once: rotation 0,1,2,3 with one bubble each
    do_reset(2);
    for (int k = 0; k < N; k++) push_frame(k, 3, 8'hFF, 0);
    drain("t037", '1, 200);
    chk("t037_nlog", grant_log.size(), 4);
    for (int k = 0; k < N && k < grant_log.size(); k++) chk("t037_order", grant_log[k], k);
    for (int k = 0; k < N; k++) chk("t037_fc", frame_count[k*32 +: 32], 1);

    // source 2 stalled by the MAC mid-frame while source 1 requests
    grant_log.delete();
    base = hs_cnt[2];
    push_frame(2, 8, 8'h0F, 0);
    wait_hs("t038_start", 2, base + 2, 100);
    p_ready = 0;
    push_frame(1, 4, 8'hFF, 0);
    cyc(6);
    chk("t038_stall_busy", busy, 1);
    chk("t038_stall_grant", grant_idx, 2);
    p_ready = 100;
    drain("t038", '1, 200);
    chk("t038_nlog", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("t038_first", grant_log[0], 2);
      chk("t038_second", grant_log[1], 1);
    end

    // enable mask 1010: only sources 1 and 3, alternating
    do_reset(2);
    src_enable = 4'b1010;
    for (int k = 0; k < N; k++) begin push_frame(k, 2, 8'hFF, 0); push_frame(k, 3, 8'h01, 0); end
    drain("t039", 4'b1010, 200);
    chk("t039_nlog", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("t039_order", grant_log[i], (i % 2) ? 3 : 1);
    chk("t039_fc0", frame_count[31:0], 0);
    chk("t039_fc2", frame_count[95:64], 0);

    // clearing enable mid-frame finishes the frame, then excludes the source
    do_reset(2);
    src_enable = '1;
    base = hs_cnt[1];
    push_frame(1, 6, 8'hFF, 0);
    wait_hs("t025_start", 1, base + 2, 100);
    src_enable = 4'b1101;
    drain("t025a", '1, 100);
    chk("t025_beats", hs_cnt[1] - base, 6);
    chk("t025_fc1", frame_count[63:32], 1);
    grant_log.delete();
    push_frame(1, 2, 8'hFF, 0);
    push_frame(3, 2, 8'hFF, 0);
    drain("t025b", 4'b1000, 100);
    chk("t025_nlog", grant_log.size(), 1);
    if (grant_log.size() > 0) chk("t025_only3", grant_log[0], 3);
    src_enable = '1;
    drain("t025c", '1, 100);

    // counter wrap from a preloaded all-ones value
    do_reset(2);
    dut.cnt_q[3] = 32'hFFFF_FFFF;
    m_cnt[3] = 32'hFFFF_FFFF;
    push_frame(3, 2, 8'hFF, 0);
    drain("t040w", '1, 100);
    chk("t040_wrap", frame_count[127:96], 0);

    // reset at beat 4 of 10: frame abandoned, no increment
    base = hs_cnt[0];
    push_frame(0, 10, 8'hFF, 0);
    wait_hs("t040r_start", 0, base + 4, 100);
    do_reset(1);
    cyc(1);
    chk("t040r_busy", busy, 0);
    chk("t040r_grant", grant_idx, N - 1);
    chk("t040r_fc0", frame_count[31:0], 0);

    // reset on the same edge as a single-beat tlast handshake
    push_frame(2, 1, 8'h07, 0);
    base = 0;
    while (!(busy && s_axis_tvalid[2] && m00_axis_tready) && base < 50) begin cyc(1); base++; end
    if (base >= 50) chk("t033_timeout", 1, 0);
    do_reset(1);
    cyc(1);
    chk("t033_fc2", frame_count[95:64], 0);
    chk("t033_busy", busy, 0);

    // single-beat frames back to back from one source
    grant_log.delete();
    for (int i = 0; i < 3; i++) push_frame(1, 1, 8'h01, 0);
    drain("t030", '1, 100);
    chk("t030_fc1", frame_count[63:32], 3);
    chk("t030_nlog", grant_log.size(), 3);

    // randomized traffic with gaps, drops, back-pressure and enable changes
    p_valid = 60; p_ready = 70; p_drop = 10;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(99) < 12) begin
        int k;
        k = $urandom_range(N - 1);
        if (src_q[k].size() < 12) push_frame(k, $urandom_range(1, 6), 8'($urandom), 0);
      end
      if (c % 25 == 24) src_enable = N'($urandom_range(1, (1 << N) - 1));
      cyc(1);
    end
    src_enable = '1;
    drain("rand", '1, 3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
